idu_decode: RTL
===============

Name: idu_decode

Overview:
- Instruction decode stage of the multicycle RV32I core, directly downstream of the instruction fetch unit.
- Accepts one fetched instruction and its PC over a valid/ready handshake.
- Registers the instruction and PC, decodes fields, immediate, op class, writeback enable and illegal/ebreak flags.
- Presents the decoded bundle to the execute stage over a second valid/ready handshake. One instruction in flight at a time.

Parameters:
WIDTH, 32, PC and datapath width; only 32 is supported.

Ports:
clk  input  1  clock
rst  input  1  reset
in_valid  input  1  fetch has an instruction; may be a single-cycle pulse
in_ready  output  1  stage can accept an instruction
in_ins  input  32  instruction word
in_pc  input  WIDTH  PC of in_ins
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute stage accepts bundle
out_pc  output  WIDTH  registered PC
out_opcls  output  4  op class: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 SYSTEM, 10 FENCE, 15 ILLEGAL
out_rs1  output  5  ins[19:15]
out_rs2  output  5  ins[24:20]
out_rd  output  5  ins[11:7]
out_funct3  output  3  ins[14:12]
out_f7b5  output  1  ins[30]
out_imm  output  32  sign-extended immediate
out_rf_wen  output  1  register-file write enable
out_illegal  output  1  illegal instruction
out_ebreak  output  1  instruction is ebreak
out_perf_ninst  output  32  retired-decode count (see Optional Feature)
out_perf_stall  output  32  output stall cycles (see Optional Feature)

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset, state goes to IDLE, out_valid=0, and every out_* bundle register and both perf counters are cleared to 0. in_ready=1 in the cycle after reset.
- FSM states: IDLE, BUSY.
- IDLE: in_ready=1, out_valid=0. When in_valid=1:
  - decode in_ins combinationally and register the full bundle plus in_pc;
  - move to BUSY. out_valid rises on the next edge (latency 1 cycle).
- BUSY: in_ready=0, out_valid=1. All out_* signals stay stable until the handshake completes. When out_ready=1, move to IDLE and set out_valid=0 on the next edge.
- No same-cycle bypass from output handshake to input acceptance. in_valid asserted during BUSY is ignored; upstream waits for in_ready.
- Immediate by format, sign-extended from the top bit:
  - I (JALR, LOAD, OPIMM): ins[31:20]
  - S: {ins[31:25], ins[11:7]}
  - B: {ins[31], ins[7], ins[30:25], ins[11:8], 0}
  - U: {ins[31:12], 12'b0}
  - J: {ins[31], ins[19:12], ins[20], ins[30:21], 0}
  - OP, SYSTEM, FENCE: 0
- out_rf_wen=1 for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, but only when rd!=0 and the instruction is not illegal.
- Illegal (out_opcls=15, out_illegal=1, out_rf_wen=0, out_imm=0) when any of:
  - ins[1:0]!=2'b11, or unknown opcode;
  - JALR with funct3!=0;
  - BRANCH with funct3 of 2 or 3;
  - LOAD with funct3 of 3, 6 or 7;
  - STORE with funct3>2;
  - OPIMM with funct3=1 and funct7!=0, or funct3=5 and funct7 not 0x00/0x20;
  - OP with funct7 not 0x00/0x20, or funct7=0x20 with funct3 not 0/5;
  - SYSTEM word other than 0x00000073 (ecall) or 0x00100073 (ebreak).
- out_ebreak=1 only for 0x00100073.
- Field outputs (rs1, rs2, rd, funct3, f7b5) are raw bit slices and are driven even for illegal instructions.
- Reset mid-BUSY drops the held instruction; no handshake completes in that cycle.

Optional Feature:
- Macro: IDU_PERF_EN.
- Defined:
  - out_perf_ninst increments by 1 on every completed output handshake (out_valid && out_ready).
  - out_perf_stall increments every cycle with out_valid && !out_ready.
  - Both are 32-bit, wrap 0xFFFFFFFF→0, and clear on rst.
- Not defined: both ports tied to constant 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- addi x1,x0,5: in_ins=0x00500093, in_pc=0x80000000, out_ready=1 → one cycle later out_valid=1, opcls=7, rd=1, rs1=0, imm=5, rf_wen=1, out_pc=0x80000000. IDLE again the following cycle.
- sw x2,-4(x1): in_ins=0xFE20AE23 → opcls=6, rs1=1, rs2=2, funct3=2, imm=0xFFFFFFFC, rf_wen=0.
- beq x0,x0,-8: in_ins=0xFE000CE3 → opcls=4, imm=0xFFFFFFF8. Then ebreak 0x00100073 → opcls=9, ebreak=1, illegal=0.
- Illegal 0xFFFFFFFF and addi-to-x0 0x00500013 → first gives opcls=15, illegal=1, rf_wen=0, imm=0. Second gives opcls=7, rf_wen=0.
- Backpressure: accept 0x00500093, hold out_ready=0 for 3 cycles while pulsing in_valid with 0x00100073 → bundle stable, in_ready=0, second instruction ignored. With IDU_PERF_EN: out_perf_stall=3, out_perf_ninst=1 after the handshake.
- Assert rst during BUSY → next cycle out_valid=0, in_ready=1, all outputs 0, counters 0.

Source files
------------

// File: rtl/idu_decode.sv
// idu_decode: instruction decode stage of the multicycle RV32I core.
//
// Takes one fetched instruction and its PC over a valid/ready handshake. It
// decodes the register fields, the sign-extended immediate, the op class, the
// writeback enable and the illegal/ebreak flags, then holds the registered
// bundle for the execute stage until that stage accepts it. Only one
// instruction is in flight at a time. The stage does not accept a new
// instruction in the same cycle that the held bundle leaves.
//
// Optional build macro: IDU_PERF_EN
//   When it is defined, out_perf_ninst counts completed output handshakes and
//   out_perf_stall counts cycles where the bundle was held back by out_ready.
//   When it is undefined, both ports are tied to 0 and no counter flops exist.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_ready fetch-side handshake (in_valid may be a one-cycle pulse)
//   in_ins, in_pc     instruction word and its PC
//   out_valid/out_ready execute-side handshake
//   out_pc            registered PC
//   out_opcls         op class (0 LUI .. 10 FENCE, 15 ILLEGAL)
//   out_rs1/rs2/rd    raw register fields
//   out_funct3/f7b5   raw funct3 field and ins[30]
//   out_imm           sign-extended immediate (0 for OP/SYSTEM/FENCE/illegal)
//   out_rf_wen        register-file write enable
//   out_illegal       illegal instruction flag
//   out_ebreak        instruction is ebreak
//   out_perf_ninst    completed-handshake count
//   out_perf_stall    output stall-cycle count
module idu_decode #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [3:0]       out_opcls,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_funct3,
  output logic             out_f7b5,
  output logic [31:0]      out_imm,
  output logic             out_rf_wen,
  output logic             out_illegal,
  output logic             out_ebreak,
  output logic [31:0]      out_perf_ninst,
  output logic [31:0]      out_perf_stall
);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;

  localparam logic [3:0] CLS_LUI    = 4'd0;
  localparam logic [3:0] CLS_AUIPC  = 4'd1;
  localparam logic [3:0] CLS_JAL    = 4'd2;
  localparam logic [3:0] CLS_JALR   = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_LOAD   = 4'd5;
  localparam logic [3:0] CLS_STORE  = 4'd6;
  localparam logic [3:0] CLS_OPIMM  = 4'd7;
  localparam logic [3:0] CLS_OP     = 4'd8;
  localparam logic [3:0] CLS_SYSTEM = 4'd9;
  localparam logic [3:0] CLS_FENCE  = 4'd10;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;

  state_t state_p1, state_nxt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_std;

  logic [3:0]         opcls_p0;
  logic signed [31:0] imm_p0;
  logic               legal_p0;
  logic               rf_wen_p0;
  logic               accept;

  assign opcode = in_ins[6:0];
  assign funct3 = in_ins[14:12];
  assign funct7 = in_ins[31:25];
  assign f7_std = (funct7 == 7'h00) || (funct7 == 7'h20);
  assign accept = (state_p1 == IDLE) && in_valid;

  // Stage p0: combinational decode of the incoming word
  always_comb begin
    opcls_p0 = CLS_ILL;
    imm_p0   = '0;
    legal_p0 = 1'b0;
    case (opcode)
      OPC_LUI: begin
        opcls_p0 = CLS_LUI;
        imm_p0   = {in_ins[31:12], 12'b0};
        legal_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        opcls_p0 = CLS_AUIPC;
        imm_p0   = {in_ins[31:12], 12'b0};
        legal_p0 = 1'b1;
      end
      OPC_JAL: begin
        opcls_p0 = CLS_JAL;
        imm_p0   = {{12{in_ins[31]}}, in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};
        legal_p0 = 1'b1;
      end
      OPC_JALR: begin
        opcls_p0 = CLS_JALR;
        imm_p0   = {{20{in_ins[31]}}, in_ins[31:20]};
        legal_p0 = (funct3 == 3'd0);
      end
      OPC_BRANCH: begin
        opcls_p0 = CLS_BRANCH;
        imm_p0   = {{20{in_ins[31]}}, in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
        legal_p0 = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OPC_LOAD: begin
        opcls_p0 = CLS_LOAD;
        imm_p0   = {{20{in_ins[31]}}, in_ins[31:20]};
        legal_p0 = (funct3 != 3'd3) && (funct3 < 3'd6);
      end
      OPC_STORE: begin
        opcls_p0 = CLS_STORE;
        imm_p0   = {{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
        legal_p0 = (funct3 <= 3'd2);
      end
      OPC_OPIMM: begin
        opcls_p0 = CLS_OPIMM;
        imm_p0   = {{20{in_ins[31]}}, in_ins[31:20]};
        // Shift-immediates carry funct7 in the immediate field.
        legal_p0 = !((funct3 == 3'd1) && (funct7 != 7'h00)) &&
                   !((funct3 == 3'd5) && !f7_std);
      end
      OPC_OP: begin
        opcls_p0 = CLS_OP;
        // funct7 = 0x20 only exists for SUB and SRA.
        legal_p0 = f7_std &&
                   !((funct7 == 7'h20) && (funct3 != 3'd0) && (funct3 != 3'd5));
      end
      OPC_SYSTEM: begin
        opcls_p0 = CLS_SYSTEM;
        legal_p0 = (in_ins == INS_ECALL) || (in_ins == INS_EBREAK);
      end
      OPC_FENCE: begin
        opcls_p0 = CLS_FENCE;
        legal_p0 = 1'b1;
      end
      default: begin
        legal_p0 = 1'b0;
      end
    endcase
    if (!legal_p0) begin
      opcls_p0 = CLS_ILL;
      imm_p0   = '0;
    end
    rf_wen_p0 = legal_p0 && (in_ins[11:7] != 5'd0) &&
                ((opcls_p0 == CLS_LUI)   || (opcls_p0 == CLS_AUIPC) ||
                 (opcls_p0 == CLS_JAL)   || (opcls_p0 == CLS_JALR)  ||
                 (opcls_p0 == CLS_LOAD)  || (opcls_p0 == CLS_OPIMM) ||
                 (opcls_p0 == CLS_OP));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_p1)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p1: registered bundle, held stable while BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc      <= '0;
      out_opcls   <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_funct3  <= '0;
      out_f7b5    <= 1'b0;
      out_imm     <= '0;
      out_rf_wen  <= 1'b0;
      out_illegal <= 1'b0;
      out_ebreak  <= 1'b0;
    end else if (accept) begin
      out_pc      <= in_pc;
      out_opcls   <= opcls_p0;
      out_rs1     <= in_ins[19:15];
      out_rs2     <= in_ins[24:20];
      out_rd      <= in_ins[11:7];
      out_funct3  <= funct3;
      out_f7b5    <= in_ins[30];
      out_imm     <= imm_p0;
      out_rf_wen  <= rf_wen_p0;
      out_illegal <= !legal_p0;
      out_ebreak  <= (in_ins == INS_EBREAK);
    end
  end

`ifdef IDU_PERF_EN
  logic [31:0] ninst_p1;
  logic [31:0] stall_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ninst_p1 <= '0;
      stall_p1 <= '0;
    end else begin
      if (out_valid && out_ready) begin
        ninst_p1 <= ninst_p1 + 32'd1;
      end
      if (out_valid && !out_ready) begin
        stall_p1 <= stall_p1 + 32'd1;
      end
    end
  end

  assign out_perf_ninst = ninst_p1;
  assign out_perf_stall = stall_p1;
`else
  assign out_perf_ninst = '0;
  assign out_perf_stall = '0;
`endif

endmodule
